// File: rtl/video_pkg.sv
// Shared definitions for the video subsystem: bus FSM states, default decode
// constants and the last valid scroll row (also used by the display).
package video_pkg;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_IDLE    = 2'd1,
    ST_COMMIT  = 2'd2
  } bus_state_t;

  localparam logic [15:0] VRAM_BASE_DEF   = 16'hF800;
  localparam logic [7:0]  PORT_SCROLL_DEF = 8'hC0;
  localparam logic [7:0]  PORT_MODE_DEF   = 8'hC1;
  localparam logic [7:0]  PORT_HRG0_DEF   = 8'h20;
  localparam logic [7:0]  PORT_HRG1_DEF   = 8'h21;

  localparam logic [4:0]  MAX_ROW = 5'd23;

  // Cycles after reset before the strobe synchronisers carry real bus values.
  localparam logic [1:0]  SYNC_SETTLE = 2'd2;

  function automatic logic in_vram(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:11] == base[15:11];
  endfunction

endpackage

// File: rtl/video_bus_if_bus_sync.sv
// Two-flop synchroniser for one asynchronous Z80 strobe; RST_VAL sets the
// value both flops take in reset (1 = strobe inactive).
module bus_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/video_bus_if.sv
// Z80 bus interface for the video block: decodes I/O and VRAM writes into
// one-cycle strobes and answers I/O read-back. HRG ports need VIDEO_HRG_EN.
//
// state      | meaning
// RELEASE    | wait for WR to be seen high (and synchronisers settled)
// IDLE       | waiting for a valid write cycle
// COMMIT     | decoded outputs and strobes are live for this one cycle
module video_bus_if
  import video_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE   = VRAM_BASE_DEF,
  parameter logic [7:0]  PORT_SCROLL = PORT_SCROLL_DEF,
  parameter logic [7:0]  PORT_MODE   = PORT_MODE_DEF,
  parameter logic [7:0]  PORT_HRG0   = PORT_HRG0_DEF,
  parameter logic [7:0]  PORT_HRG1   = PORT_HRG1_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_iorq_n,
  input  logic        i_cpu_mreq_n,
  input  logic        i_cpu_wr_n,
  input  logic        i_cpu_rd_n,
  output logic        o_counter_valid,
  output logic [4:0]  o_counter,
  output logic        o_mode80,
  output logic        o_hrg_port0_valid,
  output logic        o_hrg_port1_valid,
  output logic [7:0]  o_hrg_port0,
  output logic [7:0]  o_hrg_port1,
  output logic        o_vram_char_we,
  output logic        o_vram_attr_we,
  output logic [10:0] o_vram_waddr,
  output logic [7:0]  o_vram_wdata,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_oe
);

  logic iorq_s, mreq_s, wr_s, rd_s;

  bus_sync #(.RST_VAL(1'b1)) u_sync_iorq (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_cpu_iorq_n), .o_q(iorq_s));
  bus_sync #(.RST_VAL(1'b1)) u_sync_mreq (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_cpu_mreq_n), .o_q(mreq_s));
  bus_sync #(.RST_VAL(1'b1)) u_sync_wr   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_cpu_wr_n),   .o_q(wr_s));
  bus_sync #(.RST_VAL(1'b1)) u_sync_rd   (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_cpu_rd_n),   .o_q(rd_s));

  bus_state_t state_q, state_d;
  logic [1:0] settle_q;
  logic       wr_cycle, commit, io_wr, mem_wr;
  logic [7:0] port;

  assign port     = i_cpu_addr[7:0];
  assign wr_cycle = ~wr_s & (iorq_s ^ mreq_s);
  assign io_wr    = commit & ~iorq_s;
  assign mem_wr   = commit & ~mreq_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RELEASE;
      settle_q <= SYNC_SETTLE;
    end else begin
      state_q <= state_d;
      if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_RELEASE: if (settle_q == 2'd0 && wr_s) state_d = ST_IDLE;
      ST_IDLE: begin
        if (wr_cycle) begin
          state_d = ST_COMMIT;
          commit  = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_RELEASE;
      default:   state_d = ST_RELEASE;
    endcase
  end

  logic       counter_valid_q, char_we_q, attr_we_q, mode80_q, attr_sel_q;
  logic [4:0] counter_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      counter_valid_q <= 1'b0;
      counter_q       <= '0;
      mode80_q        <= 1'b0;
      attr_sel_q      <= 1'b0;
      char_we_q       <= 1'b0;
      attr_we_q       <= 1'b0;
      o_vram_waddr    <= '0;
      o_vram_wdata    <= '0;
    end else begin
      counter_valid_q <= 1'b0;
      char_we_q       <= 1'b0;
      attr_we_q       <= 1'b0;
      if (io_wr) begin
        if (port == PORT_SCROLL && i_cpu_data[4:0] <= MAX_ROW) begin
          counter_q       <= i_cpu_data[4:0];
          counter_valid_q <= 1'b1;
        end
        if (port == PORT_MODE) begin
          mode80_q   <= i_cpu_data[0];
          attr_sel_q <= i_cpu_data[1];
        end
      end
      if (mem_wr && in_vram(i_cpu_addr, VRAM_BASE)) begin
        o_vram_waddr <= i_cpu_addr[10:0];
        o_vram_wdata <= i_cpu_data;
        attr_we_q    <= attr_sel_q;
        char_we_q    <= ~attr_sel_q;
      end
    end
  end

  // Strobes are masked combinationally so a reset landing in COMMIT kills them at once.
  assign o_counter_valid = counter_valid_q & ~i_rst;
  assign o_vram_char_we  = char_we_q & ~i_rst;
  assign o_vram_attr_we  = attr_we_q & ~i_rst;
  assign o_counter       = counter_q;
  assign o_mode80        = mode80_q;

  logic       rd_map;
  logic [7:0] rd_val;

`ifdef VIDEO_HRG_EN
  logic       hrg0_valid_q, hrg1_valid_q;
  logic [7:0] hrg0_q, hrg1_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hrg0_valid_q <= 1'b0;
      hrg1_valid_q <= 1'b0;
      hrg0_q       <= '0;
      hrg1_q       <= '0;
    end else begin
      hrg0_valid_q <= io_wr && port == PORT_HRG0;
      hrg1_valid_q <= io_wr && port == PORT_HRG1;
      if (io_wr && port == PORT_HRG0) hrg0_q <= i_cpu_data;
      if (io_wr && port == PORT_HRG1) hrg1_q <= i_cpu_data;
    end
  end

  assign o_hrg_port0_valid = hrg0_valid_q & ~i_rst;
  assign o_hrg_port1_valid = hrg1_valid_q & ~i_rst;
  assign o_hrg_port0       = hrg0_q;
  assign o_hrg_port1       = hrg1_q;
`else
  assign o_hrg_port0_valid = 1'b0;
  assign o_hrg_port1_valid = 1'b0;
  assign o_hrg_port0       = 8'h00;
  assign o_hrg_port1       = 8'h00;
`endif

  always_comb begin
    rd_map = 1'b0;
    rd_val = 8'h00;
    if (port == PORT_SCROLL) begin
      rd_map = 1'b1;
      rd_val = {3'b000, counter_q};
    end else if (port == PORT_MODE) begin
      rd_map = 1'b1;
      rd_val = {6'b000000, attr_sel_q, mode80_q};
`ifdef VIDEO_HRG_EN
    end else if (port == PORT_HRG0) begin
      rd_map = 1'b1;
      rd_val = hrg0_q;
    end else if (port == PORT_HRG1) begin
      rd_map = 1'b1;
      rd_val = hrg1_q;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_oe   <= 1'b0;
      o_rd_data <= '0;
    end else if (~rd_s && ~iorq_s && rd_map) begin
      o_rd_oe   <= 1'b1;
      o_rd_data <= rd_val;
    end else begin
      o_rd_oe   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_bus_if.sv
// Directed self-checking bench for video_bus_if; expectations follow the
// VIDEO_HRG_EN setting of the build.
module tb_video_bus_if;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_cpu_addr = '0;
  logic [7:0]  i_cpu_data = '0;
  logic        i_cpu_iorq_n = 1'b1, i_cpu_mreq_n = 1'b1, i_cpu_wr_n = 1'b1, i_cpu_rd_n = 1'b1;
  logic        o_counter_valid, o_mode80, o_hrg_port0_valid, o_hrg_port1_valid;
  logic [4:0]  o_counter;
  logic [7:0]  o_hrg_port0, o_hrg_port1, o_vram_wdata, o_rd_data;
  logic        o_vram_char_we, o_vram_attr_we, o_rd_oe;
  logic [10:0] o_vram_waddr;

  int n_checks = 0, n_errors = 0;
  int cnt_ctr, first_ctr, cnt_char, cnt_attr, cnt_h0, cnt_h1;

  video_bus_if dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .i_cpu_iorq_n(i_cpu_iorq_n), .i_cpu_mreq_n(i_cpu_mreq_n), .i_cpu_wr_n(i_cpu_wr_n),
    .i_cpu_rd_n(i_cpu_rd_n), .o_counter_valid(o_counter_valid), .o_counter(o_counter),
    .o_mode80(o_mode80), .o_hrg_port0_valid(o_hrg_port0_valid),
    .o_hrg_port1_valid(o_hrg_port1_valid), .o_hrg_port0(o_hrg_port0),
    .o_hrg_port1(o_hrg_port1), .o_vram_char_we(o_vram_char_we),
    .o_vram_attr_we(o_vram_attr_we), .o_vram_waddr(o_vram_waddr),
    .o_vram_wdata(o_vram_wdata), .o_rd_data(o_rd_data), .o_rd_oe(o_rd_oe)
  );

  always #5 i_clk = ~i_clk;

  // Write cycle held for `hold` edges; counts strobes seen in the window.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                          input logic iorq_n, input logic mreq_n, input int hold);
    cnt_ctr = 0; first_ctr = 0; cnt_char = 0; cnt_attr = 0; cnt_h0 = 0; cnt_h1 = 0;
    @(posedge i_clk); #2;
    i_cpu_addr = addr; i_cpu_data = data;
    i_cpu_iorq_n = iorq_n; i_cpu_mreq_n = mreq_n; i_cpu_wr_n = 1'b0;
    for (int i = 1; i <= hold + 6; i++) begin
      @(posedge i_clk); #1;
      if (o_counter_valid) begin cnt_ctr++; if (first_ctr == 0) first_ctr = i; end
      if (o_vram_char_we) cnt_char++;
      if (o_vram_attr_we) cnt_attr++;
      if (o_hrg_port0_valid) cnt_h0++;
      if (o_hrg_port1_valid) cnt_h1++;
      if (i == hold) i_cpu_wr_n = 1'b1;
    end
    i_cpu_iorq_n = 1'b1; i_cpu_mreq_n = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] addr, output logic oe, output logic [7:0] data,
                         output logic oe_after);
    @(posedge i_clk); #2;
    i_cpu_addr = addr; i_cpu_iorq_n = 1'b0; i_cpu_rd_n = 1'b0;
    repeat (4) @(posedge i_clk);
    #1; oe = o_rd_oe; data = o_rd_data;
    i_cpu_iorq_n = 1'b1; i_cpu_rd_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1; oe_after = o_rd_oe;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++; if (o_counter_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ctr_valid: got %b want 0", o_counter_valid); end
    n_checks++; if (o_counter !== 5'd0) begin n_errors++; $display("FAIL rst_counter: got %0d want 0", o_counter); end
    n_checks++; if (o_mode80 !== 1'b0) begin n_errors++; $display("FAIL rst_mode80: got %b want 0", o_mode80); end
    n_checks++; if ({o_vram_char_we, o_vram_attr_we, o_rd_oe} !== 3'b000) begin n_errors++; $display("FAIL rst_we_oe: got %b want 000", {o_vram_char_we, o_vram_attr_we, o_rd_oe}); end
    n_checks++; if ({o_vram_waddr, o_vram_wdata, o_rd_data} !== 27'd0) begin n_errors++; $display("FAIL rst_vram_rd: got %h want 0", {o_vram_waddr, o_vram_wdata, o_rd_data}); end
    n_checks++; if ({o_hrg_port0_valid, o_hrg_port1_valid, o_hrg_port0, o_hrg_port1} !== 18'd0) begin n_errors++; $display("FAIL rst_hrg: got %h want 0", {o_hrg_port0_valid, o_hrg_port1_valid, o_hrg_port0, o_hrg_port1}); end
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    repeat (4) @(posedge i_clk);
  endtask

  task automatic test_scroll;
    do_write(16'h00C0, 8'h05, 1'b0, 1'b1, 3);
    n_checks++; if (cnt_ctr !== 1) begin n_errors++; $display("FAIL scroll5_pulses: got %0d want 1", cnt_ctr); end
    n_checks++; if (first_ctr !== 3) begin n_errors++; $display("FAIL scroll5_latency: got %0d want 3", first_ctr); end
    n_checks++; if (o_counter !== 5'd5) begin n_errors++; $display("FAIL scroll5_value: got %0d want 5", o_counter); end
    do_write(16'h00C0, 8'h18, 1'b0, 1'b1, 3);
    n_checks++; if (cnt_ctr !== 0) begin n_errors++; $display("FAIL scroll24_pulses: got %0d want 0", cnt_ctr); end
    n_checks++; if (o_counter !== 5'd5) begin n_errors++; $display("FAIL scroll24_hold: got %0d want 5", o_counter); end
    do_write(16'h00C0, 8'h17, 1'b0, 1'b1, 3);
    n_checks++; if (cnt_ctr !== 1) begin n_errors++; $display("FAIL scroll23_pulses: got %0d want 1", cnt_ctr); end
    n_checks++; if (o_counter !== 5'd23) begin n_errors++; $display("FAIL scroll23_value: got %0d want 23", o_counter); end
  endtask

  task automatic test_mode_vram;
    do_write(16'h00C1, 8'h03, 1'b0, 1'b1, 3);
    n_checks++; if (o_mode80 !== 1'b1) begin n_errors++; $display("FAIL mode80: got %b want 1", o_mode80); end
    n_checks++; if (cnt_ctr !== 0) begin n_errors++; $display("FAIL mode_no_strobe: got %0d want 0", cnt_ctr); end
    do_write(16'hF9FF, 8'hAB, 1'b1, 1'b0, 3);
    n_checks++; if (cnt_attr !== 1) begin n_errors++; $display("FAIL vram_attr_pulses: got %0d want 1", cnt_attr); end
    n_checks++; if (cnt_char !== 0) begin n_errors++; $display("FAIL vram_char_pulses: got %0d want 0", cnt_char); end
    n_checks++; if (o_vram_waddr !== 11'h1FF) begin n_errors++; $display("FAIL vram_waddr: got %h want 1ff", o_vram_waddr); end
    n_checks++; if (o_vram_wdata !== 8'hAB) begin n_errors++; $display("FAIL vram_wdata: got %h want ab", o_vram_wdata); end
    do_write(16'h7000, 8'h11, 1'b1, 1'b0, 3);
    n_checks++; if (cnt_attr + cnt_char !== 0) begin n_errors++; $display("FAIL vram_outside_pulses: got %0d want 0", cnt_attr + cnt_char); end
    n_checks++; if (o_vram_wdata !== 8'hAB) begin n_errors++; $display("FAIL vram_outside_data: got %h want ab", o_vram_wdata); end
  endtask

  task automatic test_read;
    logic oe, oe_after;
    logic [7:0] data;
    do_read(16'h00C1, oe, data, oe_after);
    n_checks++; if (oe !== 1'b1) begin n_errors++; $display("FAIL rd_mode_oe: got %b want 1", oe); end
    n_checks++; if (data !== 8'h03) begin n_errors++; $display("FAIL rd_mode_data: got %h want 03", data); end
    n_checks++; if (oe_after !== 1'b0) begin n_errors++; $display("FAIL rd_mode_release: got %b want 0", oe_after); end
    do_read(16'h00C0, oe, data, oe_after);
    n_checks++; if (data !== 8'h17 || oe !== 1'b1) begin n_errors++; $display("FAIL rd_scroll: got oe=%b data=%h want oe=1 data=17", oe, data); end
    do_read(16'h0055, oe, data, oe_after);
    n_checks++; if (oe !== 1'b0) begin n_errors++; $display("FAIL rd_unmapped_oe: got %b want 0", oe); end
  endtask

  task automatic test_hrg_long_wr;
    logic oe, oe_after;
    logic [7:0] data;
    do_write(16'h0020, 8'hA3, 1'b0, 1'b1, 20);
    do_read(16'h0020, oe, data, oe_after);
`ifdef VIDEO_HRG_EN
    n_checks++; if (cnt_h0 !== 1) begin n_errors++; $display("FAIL hrg0_pulses: got %0d want 1", cnt_h0); end
    n_checks++; if (o_hrg_port0 !== 8'hA3) begin n_errors++; $display("FAIL hrg0_value: got %h want a3", o_hrg_port0); end
    n_checks++; if (oe !== 1'b1 || data !== 8'hA3) begin n_errors++; $display("FAIL hrg0_read: got oe=%b data=%h want oe=1 data=a3", oe, data); end
    do_write(16'h0021, 8'h5C, 1'b0, 1'b1, 3);
    n_checks++; if (cnt_h1 !== 1 || cnt_h0 !== 0) begin n_errors++; $display("FAIL hrg1_pulses: got h1=%0d h0=%0d want 1/0", cnt_h1, cnt_h0); end
    n_checks++; if (o_hrg_port1 !== 8'h5C) begin n_errors++; $display("FAIL hrg1_value: got %h want 5c", o_hrg_port1); end
`else
    n_checks++; if (cnt_h0 !== 0) begin n_errors++; $display("FAIL hrg0_pulses: got %0d want 0", cnt_h0); end
    n_checks++; if (o_hrg_port0 !== 8'h00) begin n_errors++; $display("FAIL hrg0_value: got %h want 00", o_hrg_port0); end
    n_checks++; if (oe !== 1'b0) begin n_errors++; $display("FAIL hrg0_read_oe: got %b want 0", oe); end
`endif
    n_checks++; if (cnt_ctr !== 0) begin n_errors++; $display("FAIL hrg_no_ctr: got %0d want 0", cnt_ctr); end
  endtask

  task automatic test_both_low;
    do_write(16'hF8C0, 8'h02, 1'b0, 1'b0, 5);
    n_checks++; if (cnt_ctr + cnt_char + cnt_attr + cnt_h0 + cnt_h1 !== 0) begin n_errors++; $display("FAIL both_low_strobes: got %0d want 0", cnt_ctr + cnt_char + cnt_attr + cnt_h0 + cnt_h1); end
    n_checks++; if (o_counter !== 5'd23 || o_vram_wdata !== 8'hAB) begin n_errors++; $display("FAIL both_low_state: got ctr=%0d wdata=%h want 23/ab", o_counter, o_vram_wdata); end
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    @(posedge i_clk); #2;
    i_cpu_addr = 16'h00C0; i_cpu_data = 8'h07; i_cpu_iorq_n = 1'b0; i_cpu_wr_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++; if (o_counter_valid !== 1'b1 || o_counter !== 5'd7) begin n_errors++; $display("FAIL pre_reset_commit: got v=%b ctr=%0d want 1/7", o_counter_valid, o_counter); end
    #1; i_rst = 1'b1; #1;
    n_checks++; if (o_counter_valid !== 1'b0) begin n_errors++; $display("FAIL reset_in_commit_strobe: got %b want 0", o_counter_valid); end
    @(posedge i_clk); #1;
    n_checks++; if (o_counter !== 5'd0 || o_mode80 !== 1'b0) begin n_errors++; $display("FAIL reset_in_commit_regs: got ctr=%0d m80=%b want 0/0", o_counter, o_mode80); end
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      if (o_counter_valid) n++;
    end
    n_checks++; if (n !== 0) begin n_errors++; $display("FAIL wr_held_through_reset: got %0d pulses want 0", n); end
    i_cpu_wr_n = 1'b1; i_cpu_iorq_n = 1'b1;
    repeat (6) @(posedge i_clk);
    do_write(16'h00C0, 8'h09, 1'b0, 1'b1, 3);
    n_checks++; if (cnt_ctr !== 1 || o_counter !== 5'd9) begin n_errors++; $display("FAIL rewrite_after_reset: got pulses=%0d ctr=%0d want 1/9", cnt_ctr, o_counter); end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_mode_vram();
    test_read();
    test_hrg_long_wr();
    test_both_low();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
